// File: rtl/ofmaps_pkg.sv
// Shared types and helpers for the ofmap AXI-Stream output stage.
package ofmaps_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TDATA_WIDTH_DEF = 32;
  localparam int OFMAP_WIDTH_DEF = 8;
  localparam int LANES           = TDATA_WIDTH_DEF / OFMAP_WIDTH_DEF;

  // Clamp a signed value into the signed range of an ow-bit element.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int ow);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  function automatic logic [63:0] lanes_to_strb(input int n_lanes, input int bytes_per_lane);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n_lanes * bytes_per_lane) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ofmaps_axis_out_if.sv
// AXI-Stream bus bundle used by the ofmap output stage.
interface ofmaps_axis_out_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TSTRB;
  logic                    TLAST;
  logic                    TVALID;
  logic                    TREADY;

  modport master (output TDATA, TSTRB, TLAST, TVALID, input TREADY);
  modport slave  (input TDATA, TSTRB, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/ofmaps_out_fifo.sv
// First-word-fall-through word FIFO with occupancy count; the head entry is
// visible combinationally whenever the FIFO is not empty.
module ofmaps_out_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head     = r_mem[r_rd_ptr];
  assign w_pop      = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_push     = i_push & (~o_full | w_pop);
  assign o_overflow = i_push & o_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ofmaps_axis_out.sv
// Ofmap requantize / pack / AXI-Stream master stage.
// Build option: define OFMAPS_RELU_EN to clamp negative results to zero before packing.
module ofmaps_axis_out
  import ofmaps_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = LANES * OFMAP_WIDTH_DEF,
  parameter int PSUM_WIDTH           = 16,
  parameter int OFMAP_WIDTH          = OFMAP_WIDTH_DEF,
  parameter int FIFO_DEPTH           = 16,
  parameter int FRAME_CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FRAME_CNT_WIDTH-1:0]    frame_elems,
  input  logic [3:0]                    shift,
  input  logic signed [PSUM_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  output logic                          i_ready,
  ofmaps_axis_out_if.master             M_AXIS,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow_err
);
  localparam int NL     = C_M_AXIS_TDATA_WIDTH / OFMAP_WIDTH;
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int FIFO_W = C_M_AXIS_TDATA_WIDTH + STRB_W + 1;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  state_t                         r_state;
  logic [FRAME_CNT_WIDTH-1:0]     r_frame_elems;
  logic [FRAME_CNT_WIDTH-1:0]     r_acc_cnt;
  logic [3:0]                     r_shift;
  logic                           r_busy;
  logic                           r_frame_done;
  logic                           r_overflow;

  logic                           r_q_valid;
  logic                           r_q_last;
  logic [OFMAP_WIDTH-1:0]         r_q_data;

  logic [LANE_W-1:0]              r_lane;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_pack_data;
  logic                           r_push_valid;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_push_data;
  logic [STRB_W-1:0]              r_push_strb;
  logic                           r_push_last;

  logic                           w_accept;
  logic                           w_last_elem;
  logic                           w_pop;
  logic                           w_fifo_empty;
  logic                           w_fifo_full;
  logic                           w_fifo_ovf;
  logic [FCW-1:0]                 w_fifo_count;
  logic [FIFO_W-1:0]              w_head;
  logic signed [31:0]             w_ext;
  logic signed [31:0]             w_round;
  logic signed [31:0]             w_shifted;
  logic signed [31:0]             w_sat;
  logic signed [31:0]             w_act;
  logic [OFMAP_WIDTH-1:0]         w_q;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] w_word;
  logic                           w_word_done;

  // Threshold leaves room for words still in the requant/pack pipeline.
  assign i_ready     = (r_state == RUN) && (w_fifo_count < FCW'(FIFO_DEPTH - 1));
  assign w_accept    = i_valid & i_ready;
  assign w_last_elem = (r_acc_cnt == r_frame_elems - FRAME_CNT_WIDTH'(1));
  assign w_pop       = M_AXIS.TVALID & M_AXIS.TREADY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_frame_elems <= '0;
      r_acc_cnt     <= '0;
      r_shift       <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (frame_elems != '0)) begin
            r_frame_elems <= frame_elems;
            r_shift       <= shift;
            r_acc_cnt     <= '0;
            r_busy        <= 1'b1;
            r_state       <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + FRAME_CNT_WIDTH'(1);
            if (w_last_elem) begin
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (w_pop && M_AXIS.TLAST) begin
            r_frame_done <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Round-half-up arithmetic shift; 32 bits is ample headroom for the PSUM range.
  assign w_ext     = {{(32 - PSUM_WIDTH){i_data[PSUM_WIDTH-1]}}, i_data};
  assign w_round   = (r_shift == 4'd0) ? 32'sd0 : (32'sd1 <<< (r_shift - 4'd1));
  assign w_shifted = (w_ext + w_round) >>> r_shift;
  assign w_sat     = saturate(w_shifted, OFMAP_WIDTH);
`ifdef OFMAPS_RELU_EN
  assign w_act     = w_sat[31] ? 32'sd0 : w_sat;
`else
  assign w_act     = w_sat;
`endif
  assign w_q       = OFMAP_WIDTH'(w_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_valid <= 1'b0;
      r_q_last  <= 1'b0;
      r_q_data  <= '0;
    end else begin
      r_q_valid <= w_accept;
      if (w_accept) begin
        r_q_data <= w_q;
        r_q_last <= w_last_elem;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      assign w_word[gi*OFMAP_WIDTH +: OFMAP_WIDTH] =
        (r_lane == LANE_W'(gi)) ? r_q_data : r_pack_data[gi*OFMAP_WIDTH +: OFMAP_WIDTH];
    end
  endgenerate

  assign w_word_done = r_q_valid && (r_q_last || (r_lane == LANE_W'(NL - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane       <= '0;
      r_pack_data  <= '0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_push_strb  <= '0;
      r_push_last  <= 1'b0;
    end else begin
      r_push_valid <= w_word_done;
      if (r_q_valid) begin
        if (w_word_done) begin
          r_push_data <= w_word;
          r_push_strb <= STRB_W'(lanes_to_strb(int'(r_lane) + 1, OFMAP_WIDTH / 8));
          r_push_last <= r_q_last;
          r_pack_data <= '0;
          r_lane      <= '0;
        end else begin
          r_pack_data <= w_word;
          r_lane      <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  ofmaps_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_push_valid),
    .i_push_data ({r_push_data, r_push_strb, r_push_last}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_count     (w_fifo_count),
    .o_overflow  (w_fifo_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign M_AXIS.TVALID = ~w_fifo_empty;
  assign M_AXIS.TDATA  = w_fifo_empty ? '0 : w_head[FIFO_W-1 -: C_M_AXIS_TDATA_WIDTH];
  assign M_AXIS.TSTRB  = w_fifo_empty ? '0 : w_head[STRB_W:1];
  assign M_AXIS.TLAST  = ~w_fifo_empty & w_head[0] & ~w_fifo_full | (w_fifo_full & w_head[0]);
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign overflow_err  = r_overflow;
endmodule

// File: tb/tb_ofmaps_axis_out.sv
// Directed self-checking bench for ofmaps_axis_out.
module tb_ofmaps_axis_out;
  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        frame_elems;
  logic [3:0]         shift;
  logic signed [15:0] i_data;
  logic               i_valid;
  logic               i_ready;
  logic               busy;
  logic               frame_done;
  logic               overflow_err;

  ofmaps_axis_out_if #(.DATA_WIDTH(32)) axis ();

  ofmaps_axis_out dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_elems  (frame_elems),
    .shift        (shift),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .M_AXIS       (axis),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] bq_data[$];
  logic [3:0]  bq_strb[$];
  logic        bq_last[$];
  int          bq_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic signed [15:0] elem_q[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    if (!rst && axis.TVALID && axis.TREADY) begin
      bq_data.push_back(axis.TDATA);
      bq_strb.push_back(axis.TSTRB);
      bq_last.push_back(axis.TLAST);
      bq_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    bq_data.delete();
    bq_strb.delete();
    bq_last.delete();
    bq_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic start_frame(input int n, input int sh);
    @(posedge clk); #1;
    start = 1'b1;
    frame_elems = 16'(n);
    shift = 4'(sh);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_elems();
    int w;
    for (int i = 0; i < elem_q.size(); i++) begin
      i_valid = 1'b1;
      i_data  = elem_q[i];
      for (w = 0; w < 2000; w++) begin
        @(negedge clk);
        if (i_ready === 1'b1) break;
      end
      if (w == 2000) begin
        checks++; errors++;
        $display("FAIL accept_timeout elem %0d got no i_ready want i_ready=1", i);
        i_valid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int prev;
    prev = done_cnt;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (done_cnt > prev) break;
    end
    checks++;
    if (done_cnt == prev) begin
      errors++;
      $display("FAIL %s_done_timeout got no frame_done want frame_done pulse", tag);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; i_valid = 1'b0; i_data = '0;
    frame_elems = '0; shift = '0; axis.TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (axis.TVALID !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", axis.TVALID); end
    checks++; if (axis.TDATA !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", axis.TDATA); end
    checks++; if (axis.TSTRB !== 4'h0 || axis.TLAST !== 1'b0) begin errors++; $display("FAIL rst_tstrb_tlast got %h/%b want 0/0", axis.TSTRB, axis.TLAST); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b want 0", i_ready); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL rst_status got busy=%b done=%b ovf=%b want 0/0/0", busy, frame_done, overflow_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_start();
    start_frame(0, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || i_ready !== 1'b0) begin
      errors++; $display("FAIL zero_start got busy=%b i_ready=%b want 0/0", busy, i_ready);
    end
  endtask

  task automatic test_full_words();
    int base;
    axis.TREADY = 1'b1;
    clear_logs();
    elem_q.delete();
    for (int i = 1; i <= 8; i++) elem_q.push_back(16'(i));
    base = done_cnt;
    start_frame(8, 0);
    drive_elems();
    wait_done("t1");
    repeat (3) @(negedge clk);
    checks++;
    if (bq_data.size() != 2) begin
      errors++; $display("FAIL t1_beats got %0d want 2", bq_data.size());
    end else begin
      checks++; if (bq_data[0] !== 32'h04030201 || bq_strb[0] !== 4'hF || bq_last[0] !== 1'b0) begin
        errors++; $display("FAIL t1_beat0 got %h/%h/%b want 04030201/f/0", bq_data[0], bq_strb[0], bq_last[0]);
      end
      checks++; if (bq_data[1] !== 32'h08070605 || bq_strb[1] !== 4'hF || bq_last[1] !== 1'b1) begin
        errors++; $display("FAIL t1_beat1 got %h/%h/%b want 08070605/f/1", bq_data[1], bq_strb[1], bq_last[1]);
      end
      checks++; if (acc_cyc.size() == 8 && bq_cyc[0] - acc_cyc[3] != 3) begin
        errors++; $display("FAIL t1_latency got %0d want 3", bq_cyc[0] - acc_cyc[3]);
      end
      checks++; if (done_cyc != bq_cyc[1] + 1) begin
        errors++; $display("FAIL t1_done_timing got %0d want %0d", done_cyc, bq_cyc[1] + 1);
      end
    end
    checks++; if (done_cnt - base != 1) begin
      errors++; $display("FAIL t1_done_count got %0d want 1", done_cnt - base);
    end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL t1_busy_after got %b want 0", busy);
    end
  endtask

  task automatic test_partial_word();
    axis.TREADY = 1'b1;
    clear_logs();
    elem_q.delete();
    for (int i = 1; i <= 5; i++) elem_q.push_back(16'(i));
    start_frame(5, 0);
    drive_elems();
    wait_done("t2");
    checks++;
    if (bq_data.size() != 2) begin
      errors++; $display("FAIL t2_beats got %0d want 2", bq_data.size());
    end else begin
      checks++; if (bq_data[0] !== 32'h04030201 || bq_strb[0] !== 4'hF || bq_last[0] !== 1'b0) begin
        errors++; $display("FAIL t2_beat0 got %h/%h/%b want 04030201/f/0", bq_data[0], bq_strb[0], bq_last[0]);
      end
      checks++; if (bq_data[1] !== 32'h00000005 || bq_strb[1] !== 4'h1 || bq_last[1] !== 1'b1) begin
        errors++; $display("FAIL t2_beat1 got %h/%h/%b want 00000005/1/1", bq_data[1], bq_strb[1], bq_last[1]);
      end
    end
  endtask

  task automatic test_requant();
    logic [31:0] exp_word;
`ifdef OFMAPS_RELU_EN
    exp_word = 32'h0002007F;
`else
    exp_word = 32'hFF02807F;
`endif
    axis.TREADY = 1'b1;
    clear_logs();
    elem_q.delete();
    elem_q.push_back(16'sd1000);
    elem_q.push_back(-16'sd1000);
    elem_q.push_back(16'sd6);
    elem_q.push_back(-16'sd6);
    start_frame(4, 2);
    drive_elems();
    wait_done("t3");
    checks++;
    if (bq_data.size() != 1) begin
      errors++; $display("FAIL t3_beats got %0d want 1", bq_data.size());
    end else begin
      checks++; if (bq_data[0] !== exp_word || bq_strb[0] !== 4'hF || bq_last[0] !== 1'b1) begin
        errors++; $display("FAIL t3_requant got %h/%h/%b want %h/f/1", bq_data[0], bq_strb[0], bq_last[0], exp_word);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap;
    logic [31:0] exp_word;
    axis.TREADY = 1'b0;
    clear_logs();
    elem_q.delete();
    for (int i = 1; i <= 64; i++) elem_q.push_back(16'(i));
    start_frame(64, 0);
    fork
      drive_elems();
      begin
        repeat (80) @(negedge clk);
        checks++; if (i_ready !== 1'b0 || axis.TVALID !== 1'b1) begin
          errors++; $display("FAIL t4_stall got i_ready=%b tvalid=%b want 0/1", i_ready, axis.TVALID);
        end
        checks++; if (acc_cyc.size() != 62) begin
          errors++; $display("FAIL t4_accepted got %0d want 62", acc_cyc.size());
        end
        snap = axis.TDATA;
        checks++; if (snap !== 32'h04030201) begin
          errors++; $display("FAIL t4_head got %h want 04030201", snap);
        end
        repeat (5) @(negedge clk);
        checks++; if (axis.TDATA !== snap || axis.TSTRB !== 4'hF || axis.TVALID !== 1'b1) begin
          errors++; $display("FAIL t4_stable got %h/%h/%b want %h/f/1", axis.TDATA, axis.TSTRB, axis.TVALID, snap);
        end
        axis.TREADY = 1'b1;
      end
    join
    wait_done("t4");
    checks++;
    if (bq_data.size() != 16) begin
      errors++; $display("FAIL t4_beats got %0d want 16", bq_data.size());
    end else begin
      for (int w = 0; w < 16; w++) begin
        exp_word = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
        checks++;
        if (bq_data[w] !== exp_word || bq_last[w] !== (w == 15)) begin
          errors++; $display("FAIL t4_beat%0d got %h/%b want %h/%b", w, bq_data[w], bq_last[w], exp_word, (w == 15));
        end
      end
    end
    checks++; if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL t4_overflow got %b want 0", overflow_err);
    end
  endtask

  task automatic test_reset_midframe();
    axis.TREADY = 1'b0;
    clear_logs();
    elem_q.delete();
    for (int i = 1; i <= 10; i++) elem_q.push_back(16'(i));
    start_frame(16, 0);
    drive_elems();
    repeat (4) @(negedge clk);
    checks++; if (axis.TVALID !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL t5_pre got tvalid=%b busy=%b want 1/1", axis.TVALID, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (axis.TVALID !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_async_rst got tvalid=%b busy=%b want 0/0", axis.TVALID, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    axis.TREADY = 1'b1;
    clear_logs();
    elem_q.delete();
    for (int i = 9; i <= 12; i++) elem_q.push_back(16'(i));
    start_frame(4, 0);
    drive_elems();
    wait_done("t5");
    repeat (5) @(negedge clk);
    checks++;
    if (bq_data.size() != 1) begin
      errors++; $display("FAIL t5_beats got %0d want 1", bq_data.size());
    end else begin
      checks++; if (bq_data[0] !== 32'h0C0B0A09 || bq_strb[0] !== 4'hF || bq_last[0] !== 1'b1) begin
        errors++; $display("FAIL t5_beat got %h/%h/%b want 0c0b0a09/f/1", bq_data[0], bq_strb[0], bq_last[0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] exp_word;
`ifdef OFMAPS_RELU_EN
    exp_word = 32'h04000302;
`else
    exp_word = 32'h04FF0302;
`endif
    axis.TREADY = 1'b1;
    clear_logs();
    elem_q.delete();
    elem_q.push_back(16'sd3);
    elem_q.push_back(16'sd5);
    start_frame(4, 1);
    drive_elems();
    @(posedge clk); #1;
    start = 1'b1; frame_elems = 16'd8; shift = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    elem_q.delete();
    elem_q.push_back(-16'sd3);
    elem_q.push_back(16'sd7);
    drive_elems();
    wait_done("t6");
    checks++;
    if (bq_data.size() != 1) begin
      errors++; $display("FAIL t6_beats got %0d want 1", bq_data.size());
    end else begin
      checks++; if (bq_data[0] !== exp_word || bq_last[0] !== 1'b1) begin
        errors++; $display("FAIL t6_beat got %h/%b want %h/1", bq_data[0], bq_last[0], exp_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_start();
    test_full_words();
    test_partial_word();
    test_requant();
    test_backpressure();
    test_reset_midframe();
    test_ignore_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
